// File: rtl/down_timer_arbiter.sv
// Two-requester arbiter sharing one down-counter: IDLE -> COUNT -> DONE -> IDLE.
// Define DOWN_TIMER_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module down_timer_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] load0,
  input  logic [WIDTH-1:0] load1,
  input  logic             pause,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic       last;
  logic       any_req;
  logic       pick1;

  // Requester selection for the next grant; pick1 means requester 1 wins.
  always_comb begin
    any_req = req0 | req1;
`ifdef DOWN_TIMER_ARB_RR_EN
    pick1 = req1 & (~req0 | ~last);
`else
    pick1 = req1 & ~req0;
`endif
  end

  // Control FSM, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= {WIDTH{1'b1}};
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (any_req) begin
            state <= COUNT;
            gnt0  <= ~pick1;
            gnt1  <= pick1;
            count <= pick1 ? load1 : load0;
            last  <= pick1;
            busy  <= 1'b1;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
          end
        end
        COUNT: begin
          // Pause freezes both the count and the state; zero is terminal, no wrap.
          if (!pause) begin
            if (count != {WIDTH{1'b0}}) begin
              count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              state <= DONE;
              done0 <= gnt0;
              done1 <= gnt1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Directed bench for down_timer_arbiter (WIDTH=3); observed vector is
// {gnt0, gnt1, done0, done1, busy, count[2:0]}.
module tb_down_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] load0 = 3'd0;
  logic [2:0] load1 = 3'd0;
  logic       pause = 1'b0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [2:0] count;
  logic [7:0] obs;

  int checks = 0;
  int fails  = 0;

  down_timer_arbiter #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .load0(load0), .load1(load1), .pause(pause),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  assign obs = {gnt0, gnt1, done0, done1, busy, count};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b1; load0 = 3'd2;
    tick;
    checks++;
    if (obs !== 8'b0_0_0_0_0_111) begin
      fails++;
      $display("FAIL reset: got %b expected %b", obs, 8'b0_0_0_0_0_111);
    end
    rst = 1'b0; req0 = 1'b0;
    tick;
    checks++;
    if (obs !== 8'b0_0_0_0_0_111) begin
      fails++;
      $display("FAIL idle_hold: got %b expected %b", obs, 8'b0_0_0_0_0_111);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp [0:5];
    exp = '{8'b1_0_0_0_1_011, 8'b1_0_0_0_1_010, 8'b1_0_0_0_1_001,
            8'b1_0_0_0_1_000, 8'b1_0_1_0_1_000, 8'b0_0_0_0_0_000};
    req0 = 1'b1; load0 = 3'd3;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (obs !== exp[i]) begin
        fails++;
        $display("FAIL basic cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i == 0) req0 = 1'b0;
    end
  endtask

  task automatic test_load_zero;
    logic [7:0] exp [0:2];
    exp = '{8'b0_1_0_0_1_000, 8'b0_1_0_1_1_000, 8'b0_0_0_0_0_000};
    req1 = 1'b1; load1 = 3'd0; load0 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (obs !== exp[i]) begin
        fails++;
        $display("FAIL load_zero cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i == 0) req1 = 1'b0;
    end
  endtask

  task automatic test_arbitration;
    logic       g;
    logic [2:0] cnt;
    logic [7:0] exp;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; load0 = 3'd2; load1 = 3'd2;
    for (int k = 0; k < 3; k++) begin
`ifdef DOWN_TIMER_ARB_RR_EN
      g = (k % 2 == 1);
`else
      g = 1'b0;
`endif
      cnt = 3'd2;
      for (int p = 0; p < 5; p++) begin
        tick;
        if (p < 3) begin
          exp = {~g, g, 2'b00, 1'b1, cnt};
          cnt = cnt - 3'd1;
        end else if (p == 3) begin
          exp = {~g, g, ~g, g, 1'b1, 3'd0};
        end else begin
          exp = 8'b0_0_0_0_0_000;
        end
        checks++;
        if (obs !== exp) begin
          fails++;
          $display("FAIL arbitration grant %0d cycle %0d: got %b expected %b", k, p, obs, exp);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_pause;
    logic [7:0] exp [0:15];
    exp = '{8'b1_0_0_0_1_101, 8'b1_0_0_0_1_100, 8'b1_0_0_0_1_011,
            8'b1_0_0_0_1_011, 8'b1_0_0_0_1_011, 8'b1_0_0_0_1_011,
            8'b1_0_0_0_1_010, 8'b1_0_0_0_1_001, 8'b1_0_0_0_1_000,
            8'b1_0_1_0_1_000, 8'b0_0_0_0_0_000,
            8'b0_1_0_0_1_001, 8'b0_1_0_0_1_001, 8'b0_1_0_0_1_000,
            8'b0_1_0_1_1_000, 8'b0_0_0_0_0_000};
    req0 = 1'b1; load0 = 3'd5; pause = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      checks++;
      if (obs !== exp[i]) begin
        fails++;
        $display("FAIL pause cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      case (i)
        0:  req0 = 1'b0;
        2:  pause = 1'b1;
        5:  pause = 1'b0;
        10: begin pause = 1'b1; req1 = 1'b1; load1 = 3'd1; end
        11: req1 = 1'b0;
        12: pause = 1'b0;
        14: pause = 1'b1;
        15: pause = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_count;
    logic [7:0] exp [0:4];
    exp = '{8'b1_0_0_0_1_100, 8'b1_0_0_0_1_011, 8'b1_0_0_0_1_010,
            8'b0_0_0_0_0_111, 8'b0_0_0_0_0_111};
    req0 = 1'b1; load0 = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (obs !== exp[i]) begin
        fails++;
        $display("FAIL reset_mid_count cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i == 0) req0 = 1'b0;
      if (i == 2) rst = 1'b1;
      if (i == 3) rst = 1'b0;
    end
  endtask

  task automatic test_no_effect;
    logic [7:0] exp [0:10];
    exp = '{8'b1_0_0_0_1_100, 8'b1_0_0_0_1_011, 8'b1_0_0_0_1_010,
            8'b1_0_0_0_1_001, 8'b1_0_0_0_1_000, 8'b1_0_1_0_1_000,
            8'b0_0_0_0_0_000, 8'b0_1_0_0_1_001, 8'b0_1_0_0_1_000,
            8'b0_1_0_1_1_000, 8'b0_0_0_0_0_000};
    req0 = 1'b1; load0 = 3'd4;
    for (int i = 0; i < 11; i++) begin
      tick;
      checks++;
      if (obs !== exp[i]) begin
        fails++;
        $display("FAIL no_effect cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i == 0) begin req0 = 1'b0; load0 = 3'd7; req1 = 1'b1; load1 = 3'd1; end
      if (i == 7) req1 = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_load_zero;
    test_arbitration;
    test_pause;
    test_reset_mid_count;
    test_no_effect;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/down_timer_arbiter.md
DOWN_TIMER_ARBITER -- requirements
Module: down_timer_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the down-counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: countdown requests from requester 0 and requester 1.
REQ-005 The block SHALL have ports load0 and load1, input, WIDTH bits each: start value of the count for each requester, sampled at grant.
REQ-006 The block SHALL have port pause, input, 1 bit: freezes the count while high.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: registered, one-hot or zero, high while that requester owns the counter.
REQ-008 The block SHALL have ports done0 and done1, output, 1 bit each: registered one-cycle pulse when the owner's countdown completes.
REQ-009 The block SHALL have port busy, output, 1 bit: high in COUNT and DONE states.
REQ-010 The block SHALL have port count, output, WIDTH bits: current shared down-counter value.

Function
REQ-011 The block SHALL implement the FSM states IDLE, COUNT and DONE.
REQ-012 In IDLE with any req high at an edge, the block SHALL grant one requester at that edge: next cycle is COUNT, gntX=1, count=loadX; the latency from req to gnt is 1 cycle.
REQ-013 In IDLE with no req, the block SHALL hold count unchanged and keep all gnt and done low.
REQ-014 In COUNT with pause=0 and count!=0, the block SHALL decrement count by 1 per edge.
REQ-015 In COUNT with pause=1, the block SHALL hold count and state; pause SHALL be ignored in IDLE and DONE.
REQ-016 In COUNT with pause=0 and count==0, the block SHALL move to DONE, with doneX=1 for exactly that DONE cycle and gntX still high; count SHALL stay 0 and never wrap.
REQ-017 From DONE, the block SHALL always go to IDLE at the next edge, dropping gnt; new grants SHALL occur only from IDLE, which gives a 1-cycle bubble.
REQ-018 A load value L SHALL give L+1 COUNT cycles; L=0 SHALL give 1 COUNT cycle, then DONE.
REQ-019 Arbitration SHALL be non-preemptive: req changes and load changes during COUNT/DONE SHALL have no effect, and the owner need not hold req.
REQ-020 The block SHALL keep a last-served pointer (1 bit), updated at every grant.

Reset
REQ-021 When rst=1 at an edge, the block SHALL force state=IDLE, count={WIDTH{1'b1}}, gnt0=gnt1=0, done0=done1=0, busy=0 and last-served=1, regardless of the current state.
REQ-022 Reset mid-COUNT SHALL abandon the countdown with no done pulse; rst SHALL take priority over all other inputs.

Configuration
REQ-023 With macro DOWN_TIMER_ARB_RR_EN defined, the block SHALL use round-robin arbitration: if both requesters are pending in IDLE, it SHALL grant the one not equal to last-served; a single pending requester SHALL always win.
REQ-024 Without DOWN_TIMER_ARB_RR_EN, the block SHALL use fixed priority with req0 over req1; the last-served pointer SHALL still exist but SHALL not affect grants.

Verification
REQ-025 The bench SHALL cover: reset, then req0=1 with load0=3 -> gnt0 next cycle, count 3,2,1,0, then done0 pulse (count=0), then IDLE; busy high for 5 cycles.
REQ-026 The bench SHALL cover: load1=0 and req1 only -> 1 COUNT cycle at 0, then done1, then IDLE.
REQ-027 The bench SHALL cover: req0=req1=1 held continuously, load=2 for both -> with RR_EN, grants alternate gnt0, gnt1, gnt0 with one idle cycle between; without RR_EN, only gnt0.
REQ-028 The bench SHALL cover: load0=5 with pause=1 for 3 cycles at count=3 -> count holds 3 for 3 cycles, then resumes; done0 arrives 3 cycles later than unpaused.
REQ-029 The bench SHALL cover: rst=1 at count=2 in COUNT -> next cycle IDLE, count=7 (WIDTH=3), gnt=0, no done pulse.
REQ-030 The bench SHALL cover: req0 dropped and load0 changed mid-COUNT -> countdown continues from the original value and done0 still pulses.
